mem_arbiter: RTL and testbench

//   Shares the single-port 1024-word unified BRAM between cpu_core's instruction-fetch and load/store ports.

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port BRAM: data port has priority, and a
// starvation counter forces a fetch grant after STARVE_LIMIT blocked fetch cycles.
module mem_arbiter #(
  parameter int WORD_SIZE    = 32,
  parameter int NUM_WORDS    = 1024,
  parameter int STARVE_LIMIT = 4,
  localparam int ADDR_SIZE   = $clog2(NUM_WORDS),
  localparam int STRB_SIZE   = WORD_SIZE / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 i_req_valid,
  output logic                 i_req_ready,
  input  logic [ADDR_SIZE-1:0] i_req_addr,
  output logic                 i_rsp_valid,
  output logic [WORD_SIZE-1:0] i_rsp_data,
  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic [ADDR_SIZE-1:0] d_req_addr,
  input  logic                 d_req_we,
  input  logic [STRB_SIZE-1:0] d_req_wstrb,
  input  logic [WORD_SIZE-1:0] d_req_wdata,
  output logic                 d_rsp_valid,
  output logic [WORD_SIZE-1:0] d_rsp_data,
  output logic                 mem_en,
  output logic [STRB_SIZE-1:0] mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  // owner state | meaning
  // OWN_NONE    | no access issued last cycle, no response due
  // OWN_I       | fetch granted last cycle, fetch response due now
  // OWN_D       | data access granted last cycle, data response/ack due now
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic [7:0] STARVE_MAX = STARVE_LIMIT[7:0];

  logic [1:0] owner_q, owner_d;
  logic       we_q, we_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       i_grant, d_grant;

  // Readies are held low during reset so nothing is accepted while state clears.
  always_comb begin
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    if (!rst && !hold) begin
      if (starve_cnt_q == STARVE_MAX && i_req_valid) begin
        i_req_ready = 1'b1;
      end else if (d_req_valid) begin
        d_req_ready = 1'b1;
      end else begin
        i_req_ready = i_req_valid;
      end
    end
  end

  assign i_grant = i_req_valid & i_req_ready;
  assign d_grant = d_req_valid & d_req_ready;

  always_comb begin
    mem_en    = i_grant | d_grant;
    mem_addr  = d_grant ? d_req_addr : i_req_addr;
    mem_we    = (d_grant && d_req_we) ? d_req_wstrb : '0;
    mem_wdata = d_req_wdata;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (d_grant) begin
      owner_d = OWN_D;
    end else if (i_grant) begin
      owner_d = OWN_I;
    end
    we_d = d_grant & d_req_we;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!hold) begin
      if (!i_req_valid || i_req_ready) begin
        starve_cnt_d = 8'd0;
      end else if (starve_cnt_q < STARVE_MAX) begin
        starve_cnt_d = starve_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_NONE;
      we_q         <= 1'b0;
      starve_cnt_q <= 8'd0;
    end else begin
      owner_q      <= owner_d;
      we_q         <= we_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // A response due in the reset cycle is suppressed rather than delivered.
  always_comb begin
    i_rsp_valid = !rst && (owner_q == OWN_I);
    d_rsp_valid = !rst && (owner_q == OWN_D);
    i_rsp_data  = i_rsp_valid ? mem_rdata : '0;
    d_rsp_data  = (d_rsp_valid && !we_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte-writable BRAM model.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int A  = 10;
  localparam int SB = 4;

  logic          clk = 1'b0;
  logic          rst, hold;
  logic          i_req_valid, i_req_ready;
  logic [A-1:0]  i_req_addr;
  logic          i_rsp_valid;
  logic [W-1:0]  i_rsp_data;
  logic          d_req_valid, d_req_ready;
  logic [A-1:0]  d_req_addr;
  logic          d_req_we;
  logic [SB-1:0] d_req_wstrb;
  logic [W-1:0]  d_req_wdata;
  logic          d_rsp_valid;
  logic [W-1:0]  d_rsp_data;
  logic          mem_en;
  logic [SB-1:0] mem_we;
  logic [A-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;

  logic [W-1:0] ram [0:1023];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(32), .NUM_WORDS(1024), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Read-first BRAM: a write cycle returns the old word on mem_rdata.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < SB; b++) begin
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  initial begin
    bit prev_f;
    bit exp_f;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    ram[5]    = 32'h5555_5555;
    ram[16]   = 32'hDEAD_BEEF;
    ram[1023] = 32'hAABB_CCDD;
    mem_rdata = '0;
    rst = 1'b1; hold = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 10'h010;
    d_req_valid = 1'b1; d_req_addr = 10'h005; d_req_we = 1'b0;
    d_req_wstrb = '0; d_req_wdata = '0;

    // reset with both requesters valid
    tick(); tick();
    look();
    chk("rst_i_ready", i_req_ready, 0);
    chk("rst_d_ready", d_req_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    tick();
    rst = 1'b0;
    look();
    chk("post_rst_d_ready", d_req_ready, 1);
    chk("post_rst_i_ready", i_req_ready, 0);
    chk("post_rst_mem_en", mem_en, 1);
    chk("post_rst_addr", mem_addr, 10'h005);
    chk("post_rst_i_rsp", i_rsp_valid, 0);
    chk("post_rst_d_rsp", d_rsp_valid, 0);
    tick();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    look();
    chk("first_d_rsp_valid", d_rsp_valid, 1);
    chk("first_d_rsp_data", d_rsp_data, 32'h5555_5555);

    // fetch only
    tick();
    i_req_valid = 1'b1; i_req_addr = 10'h010;
    look();
    chk("fetch_ready", i_req_ready, 1);
    chk("fetch_mem_en", mem_en, 1);
    chk("fetch_addr", mem_addr, 10'h010);
    chk("fetch_we", mem_we, 0);
    tick();
    i_req_valid = 1'b0;
    look();
    chk("fetch_rsp_valid", i_rsp_valid, 1);
    chk("fetch_rsp_data", i_rsp_data, 32'hDEAD_BEEF);
    chk("fetch_no_d_rsp", d_rsp_valid, 0);
    chk("idle_mem_en", mem_en, 0);

    // partial write then read back
    tick();
    d_req_valid = 1'b1; d_req_addr = 10'h3FF; d_req_we = 1'b1;
    d_req_wstrb = 4'b0011; d_req_wdata = 32'h1234_5678;
    look();
    chk("wr_ready", d_req_ready, 1);
    chk("wr_mem_we", mem_we, 4'b0011);
    chk("wr_wdata", mem_wdata, 32'h1234_5678);
    chk("wr_addr", mem_addr, 10'h3FF);
    tick();
    d_req_we = 1'b0;
    look();
    chk("wr_ack_valid", d_rsp_valid, 1);
    chk("wr_ack_data", d_rsp_data, 0);
    chk("rd_mem_we", mem_we, 0);
    tick();
    d_req_valid = 1'b0;
    look();
    chk("rd_rsp_valid", d_rsp_valid, 1);
    chk("rd_rsp_data", d_rsp_data, 32'hAABB_5678);

    // continuous contention: fetch forced on cycles 4 and 9
    tick();
    i_req_valid = 1'b1; i_req_addr = 10'h010;
    d_req_valid = 1'b1; d_req_addr = 10'h005;
    prev_f = 1'b0;
    for (int k = 0; k < 10; k++) begin
      look();
      exp_f = (k == 4) || (k == 9);
      chk($sformatf("cont_i_ready_%0d", k), i_req_ready, exp_f);
      chk($sformatf("cont_d_ready_%0d", k), d_req_ready, !exp_f);
      chk($sformatf("cont_addr_%0d", k), mem_addr, exp_f ? 10'h010 : 10'h005);
      if (k == 0) begin
        chk("cont_rsp0_i", i_rsp_valid, 0);
        chk("cont_rsp0_d", d_rsp_valid, 0);
      end else begin
        chk($sformatf("cont_i_rsp_%0d", k), i_rsp_valid, prev_f);
        chk($sformatf("cont_d_rsp_%0d", k), d_rsp_valid, !prev_f);
        chk($sformatf("cont_data_%0d", k), prev_f ? i_rsp_data : d_rsp_data,
            prev_f ? 32'hDEAD_BEEF : 32'h5555_5555);
      end
      prev_f = exp_f;
      tick();
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    look();
    chk("cont_last_i_rsp", i_rsp_valid, 1);
    chk("cont_last_d_rsp", d_rsp_valid, 0);

    // hold freezes the starvation count
    tick();
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    look();
    chk("hold_pre0_d", d_req_ready, 1);
    tick();
    look();
    chk("hold_pre1_d", d_req_ready, 1);
    tick();
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      look();
      chk($sformatf("hold_i_ready_%0d", h), i_req_ready, 0);
      chk($sformatf("hold_d_ready_%0d", h), d_req_ready, 0);
      chk($sformatf("hold_mem_en_%0d", h), mem_en, 0);
      chk($sformatf("hold_d_rsp_%0d", h), d_rsp_valid, h == 0);
      tick();
    end
    hold = 1'b0;
    for (int r = 0; r < 4; r++) begin
      look();
      chk($sformatf("release_i_ready_%0d", r), i_req_ready, r == 2);
      chk($sformatf("release_d_ready_%0d", r), d_req_ready, r != 2);
      tick();
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;

    // reset right after a grant: response dropped, counter cleared
    tick();
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    tick();
    look();
    chk("pre_rst_grant", d_req_ready, 1);
    tick();
    rst = 1'b1; i_req_valid = 1'b0; d_req_valid = 1'b0;
    look();
    chk("rst_drop_d_rsp", d_rsp_valid, 0);
    chk("rst_drop_i_rsp", i_rsp_valid, 0);
    tick();
    rst = 1'b0;
    look();
    chk("after_rst_d_rsp", d_rsp_valid, 0);
    chk("after_rst_i_rsp", i_rsp_valid, 0);
    tick();
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      look();
      chk($sformatf("post_rst_cnt_i_%0d", k), i_req_ready, k == 4);
      tick();
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    look();
    chk("post_rst_fetch_rsp", i_rsp_data, 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
